// File: rtl/pcihellocore_ledport_ex.sv
// Avalon-MM LED/GPIO output port with SET/CLEAR/TOGGLE write aliases.
// Define LEDPORT_BLINK_EN to build the per-bit blink engine (addresses 4-6).
module pcihellocore_ledport_ex #(
    parameter int                WIDTH       = 32,
    parameter int                PERIOD_W    = 24,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             blink_phase
);

    if (WIDTH < 1 || WIDTH > 32 || PERIOD_W < 1 || PERIOD_W > 32) begin : g_bad_param
        $error("pcihellocore_ledport_ex: WIDTH and PERIOD_W must be in 1..32");
    end

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                3'd0:    data_d = wd;
                3'd1:    data_d = data_q | wd;
                3'd2:    data_d = data_q & ~wd;
                3'd3:    data_d = data_q ^ wd;
                default: data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef LEDPORT_BLINK_EN
    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (wr && address == 3'd4) begin
            mask_d = wd;
        end
        // A period write restarts the prescaler and wins over a coincident wrap.
        if (wr && address == 3'd5) begin
            period_d = writedata[PERIOD_W-1:0];
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - ONE_P) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + ONE_P;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign blink_phase = phase_q;
    assign out_port    = data_q ^ (mask_q & {WIDTH{phase_q}});
`else
    assign blink_phase = 1'b0;
    assign out_port    = data_q;
`endif

    // DATA reads return the stored value, not the blink-blended output.
    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'(data_q);
`ifdef LEDPORT_BLINK_EN
            3'd4:    readdata = 32'(mask_q);
            3'd5:    readdata = 32'(period_q);
            3'd6:    readdata = {30'b0, period_q != '0, phase_q};
`endif
            default: readdata = '0;
        endcase
    end

endmodule
